// File: rtl/mig_tree_pipe.sv
// Pipelined majority-inverter tree evaluator: 3^LEVELS complemented leaves reduced by
// MAJ3 gates, one registered tree level per stage, valid/ready flow control, result statistics.
module mig_tree_pipe #(
    parameter  int LEVELS = 3,
    parameter  int CNT_W  = 16,
    localparam int N      = 3 ** LEVELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_leaves,
    input  logic [N-1:0]     inv_mask,
    input  logic             cnt_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [CNT_W-1:0] result_count,
    output logic [CNT_W-1:0] ones_count
);

    // Registered nodes of levels 1..LEVELS, stored level by level; the root is the top bit.
    localparam int TOT = (N - 1) / 2;
    localparam int ALL = N + TOT;

    function automatic int pow3(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 3;
        return r;
    endfunction

    // Offset of level k inside {node_q, leaf_x}, leaves being level 0.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o = o + pow3(LEVELS - i);
        return o;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [N-1:0]      leaf_x;
    logic [ALL-1:0]    nodes;
    logic [TOT-1:0]    node_q, node_d;
    logic [LEVELS:1]   valid_q, valid_d;
    logic [LEVELS:0]   valid_in;
    logic [LEVELS:1]   ready;
    logic [CNT_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic              out_hs;

    assign leaf_x   = in_leaves ^ inv_mask;
    assign nodes    = {node_q, leaf_x};
    assign valid_in = {valid_q, in_valid};

    // A stage can take new data when empty or when its occupant moves on this cycle.
    always_comb begin : ready_chain
        logic r;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ready = '0;
        // NOTE: blocking assignments here make r ripple from the output back to stage 1 within one evaluation.
        r = out_ready;
        for (int k = LEVELS; k >= 1; k--) begin
            r        = ~valid_q[k] | r;
            ready[k] = r;
        end
    end

    always_comb begin
        valid_d = valid_q;
        node_d  = node_q;
        for (int k = 1; k <= LEVELS; k++) begin
            if (ready[k]) begin
                valid_d[k] = valid_in[k-1];
            end
            // Data only moves with a valid token, so idle leaf inputs never reach the tree.
            if (ready[k] && valid_in[k-1]) begin
                for (int j = 0; j < pow3(LEVELS - k); j++) begin
                    node_d[lvl_off(k) - N + j] = maj3(nodes[lvl_off(k-1) + 3*j],
                                                      nodes[lvl_off(k-1) + 3*j + 1],
                                                      nodes[lvl_off(k-1) + 3*j + 2]);
                end
            end
        end
    end

    assign out_hs = valid_q[LEVELS] & out_ready;

    always_comb begin
        result_d = result_q;
        ones_d   = ones_q;
        if (cnt_clear) begin
            result_d = '0;
            ones_d   = '0;
        end else if (out_hs) begin
            result_d = result_q + CNT_W'(1);
            ones_d   = ones_q + CNT_W'(node_q[TOT-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            // NOTE: the node registers are reset too, so out_bit reads a defined 0 before the first result.
            node_q   <= '0;
            result_q <= '0;
            ones_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge values of its neighbours.
            valid_q  <= valid_d;
            node_q   <= node_d;
            result_q <= result_d;
            ones_q   <= ones_d;
        end
    end

    assign in_ready     = ready[1];
    assign out_valid    = valid_q[LEVELS];
    assign out_bit      = node_q[TOT-1];
    assign result_count = result_q;
    assign ones_count   = ones_q;

endmodule

// File: doc/mig_tree_pipe.md
Name:
mig_tree_pipe

Overview:
- Parametrised, pipelined evaluator for a complete majority-inverter tree.
  - 3^LEVELS leaf bits, each optionally complemented.
  - Reduced by 3-input majority gates, one registered tree level per stage.
- Accepts one leaf vector per cycle under valid/ready handshake, with full backpressure.
- Keeps result/ones statistics counters.
- Sits beside the flat combinational MIG netlists as a streaming, reconfigurable evaluation engine for regression and equivalence runs.

Parameters:
- LEVELS, 3, tree depth; leaf count N = 3^LEVELS (27 at default); must be >= 1.
- CNT_W, 16, width of result_count and ones_count.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  leaf vector present.
- in_ready  output  1  stage 1 can accept this cycle.
- in_leaves  input  N  leaf values; bit i is leaf i.
- inv_mask  input  N  per-leaf complement; sampled together with in_leaves.
- cnt_clear  input  1  synchronous clear of both counters.
- out_valid  output  1  result present in final stage.
- out_ready  input  1  consumer accepts result.
- out_bit  output  1  tree root value.
- result_count  output  CNT_W  number of completed output handshakes.
- ones_count  output  CNT_W  number of handshaked results equal to 1.

Behaviour:
- Leaf prep: x[i] = in_leaves[i] ^ inv_mask[i].
- Gate function: MAJ(a,b,c) = ab|ac|bc.
- Level 1, node j = MAJ(x[3j], x[3j+1], x[3j+2]), j = 0..N/3-1.
- Level k, node j = MAJ of level k-1 nodes 3j, 3j+1, 3j+2.
- Root is the single node of level LEVELS.
- Pipeline: stage k (1..LEVELS) registers level-k node vector (width 3^(LEVELS-k)) plus valid_k.
- Stage 1 computes from the combinational leaf prep.
- Latency: a vector accepted at edge t gives out_valid=1 at edge t+LEVELS-1 (visible the cycle after the LEVELS-th capture), provided there is no stall.
- Ready chain: ready_k = !valid_k | ready_{k+1}, with ready_{LEVELS+1} = out_ready; in_ready = ready_1. This is a combinational chain, so there are no bubbles.
- Stage k loads when ready_k:
  - valid_k <= valid_{k-1}, with valid_0 = in_valid.
  - Data is loaded only when the incoming valid is 1.
- Stall: while out_ready=0 and out_valid=1:
  - out_bit and all occupied stages hold.
  - Empty upstream stages still fill.
  - Once full, in_ready=0.
- Throughput: 1 result per cycle when out_ready held 1.
- out_bit = root register; out_valid = valid_LEVELS.
- Counters on output handshake (out_valid & out_ready):
  - result_count increments.
  - ones_count increments if out_bit=1.
  - Both wrap modulo 2^CNT_W, no saturation.
- cnt_clear=1 zeroes both counters. It has priority over a same-cycle increment and does not affect the pipeline.
- Reset values: all valid_k=0, all stage data=0, out_valid=0, out_bit=0, both counters 0.
- in_ready is 1 whenever rst is low after reset.
- Reset mid-operation discards in-flight vectors immediately; no partial result is ever emitted.
- Leaf data is don't-care when in_valid=0; the stage data registers must not load from it.
- LEVELS=1 degenerates to a single registered MAJ3 with latency 1.

Test Plan:
- Default params:
  - in_leaves=27'h7FFFFFF, inv_mask=0, out_ready=1 → out_valid=1 three cycles after acceptance, out_bit=1, result_count=1, ones_count=1.
  - in_leaves=27'h0000007, mask=0 → out_bit=0: one level-1 node high, level-2 node 0 gets MAJ(1,0,0)=0.
  - in_leaves=27'h000361B, mask=0 → out_bit=1: level-1 nodes 0,1,3,4 high, level-2 nodes 0,1 high.
  - in_leaves=0, inv_mask=27'h7FFFFFF → out_bit=1. Then in_leaves=27'h000361B with same mask → out_bit=0.
- Backpressure: out_ready=0, stream 5 vectors with in_valid=1.
  - Exactly 3 are accepted, then in_ready=0.
  - out_bit stays stable.
  - Raising out_ready delivers results in order at one per cycle; result_count reaches 5.
- Counters and reset:
  - Assert cnt_clear in the same cycle as a handshake → both counters read 0.
  - Assert rst with 2 vectors in flight → out_valid=0 immediately, nothing emitted afterwards, counters 0.
- LEVELS=1, CNT_W=2:
  - in_leaves=3'b101 → out_bit=1 after 1 cycle.
  - 5 handshakes → result_count wraps to 1.
